cipher_ctrl: RTL
================

# cipher_ctrl

Sequencer and arbiter for the shared byte-serial shift-cipher datapath. It grants one of two requesters (requester 0 = encrypt, requester 1 = decrypt) exclusive use of the cipher for one MSG_LEN-byte message. It latches that requester's key at grant, streams the message through a one-stage registered add/subtract datapath with valid/ready flow control, and releases the grant after the last byte leaves. It sits between the message-producing clients and the downstream byte sink, replacing the purely combinational array encrypt/decrypt path.

## Interface
- MSG_LEN, 9, bytes per message (job); legal range 1..255
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  2  per-requester job request; bit 0 = encrypt, bit 1 = decrypt
- key_in  in  8  shift key, sampled on the grant edge
- gnt  out  2  one-hot grant, held for the whole job; reset 2'b00
- in_valid  in  1  input byte valid
- in_data  in  8  input byte from the granted requester
- in_ready  out  1  input byte accepted when in_valid && in_ready; reset 0
- out_valid  out  1  output byte valid; reset 0
- out_data  out  8  transformed byte; reset 8'h00
- out_last  out  1  qualifies the MSG_LEN-th output byte; reset 0
- out_ready  in  1  sink accepts when out_valid && out_ready
- busy  out  1  high in XFER and DONE; reset 0
- done  out  1  one-cycle pulse at job end; reset 0

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE: when req != 0, go to XFER on the next edge.
  - Set gnt to the winner.
  - Latch key_in and mode (mode = winner index).
  - Clear in_cnt and out_cnt.
- Arbitration is round-robin on a last-grant pointer; the pointer resets to 1, so requester 0 wins the first simultaneous request.
  - If only one req bit is set, that requester wins regardless of the pointer.
- XFER: in_ready = (in_cnt < MSG_LEN) && (!out_valid || out_ready).
  - Each input handshake loads the output register and increments in_cnt.
  - Each output handshake increments out_cnt.
  - out_last = out_valid && (out_cnt == MSG_LEN-1).
- Output handshake with out_last → DONE.
- DONE: done = 1, gnt cleared on exit; always go to IDLE next cycle.
- req deasserting mid-job is ignored; the job runs to completion. Requester identity is conveyed only by gnt.
- Arithmetic (default): encrypt out = (in + key) mod 256; decrypt out = (in − key) mod 256; natural 8-bit wrap.
- Counters are 8 bits wide; with MSG_LEN ≤ 255 they never wrap.
- Reset asserted mid-job: all outputs go to their reset values immediately (asynchronously), the job is discarded, the pointer resets to 1, and the FSM returns to IDLE.

## Timing
- Grant latency: req sampled high in IDLE at edge N → gnt valid after edge N, in_ready possible in the same cycle.
- Datapath latency: input handshake at edge K → out_valid/out_data valid after edge K (1 cycle).
- Full throughput is 1 byte/cycle while out_ready is held high.
- Backpressure: out_valid && !out_ready → in_ready low; out_data is held stable until accepted.
- Job end: last output handshake at edge L → done high L..L+1 → gnt 0 after L+1.
- Next grant comes at edge L+2 at the earliest, i.e. a 2-cycle bubble between jobs.
- A simultaneous input and output handshake in the same cycle is legal; the register is replaced, not emptied.

## Configuration
- CIPHER_CTRL_ALPHA_EN defined:
  - Only 'A'..'Z' (8'h41..8'h5A) are shifted, and they wrap within the alphabet.
  - out = 'A' + ((in − 'A' ± (key mod 26)) mod 26).
  - All other bytes pass through unchanged.
  - key mod 26 is computed once at latch time.
- Not defined: plain mod-256 byte shift on every byte.
- Interface and timing are identical in both builds.

## Test plan
- Encrypt "PARASCHIV", key 3, out_ready = 1 → gnt = 01, out bytes "SDUDVFKLY" on consecutive cycles, out_last on byte 9, done 1 cycle later. Then decrypt "SDUDVFKLY", key 3 → "PARASCHIV".
- Default build, encrypt 8'hFE key 3 → 8'h01; decrypt 8'h01 key 3 → 8'hFE.
- CIPHER_CTRL_ALPHA_EN build:
  - Encrypt "XYZ A" key 3 → "ABC D"; the space passes unchanged.
  - Key 29 gives the same result as key 3.
- req = 11 from reset → first gnt = 01; with req still 11 after done, next gnt = 10; then 01 again (alternating).
- out_ready low for 5 cycles mid-message → in_ready low, out_data stable for those cycles. Full job still delivers exactly 9 bytes, no loss or duplication.
- rst_n pulsed low after byte 4 of a job → gnt, out_valid, busy, done all 0 immediately. A fresh req = 10 then gets grant and a complete 9-byte job.

Source files
------------

// File: rtl/cipher_ctrl_if.sv
// cipher_ctrl_if: request/grant, input byte stream and output byte stream
// of the shared shift-cipher sequencer.
interface cipher_ctrl_if;
    logic [1:0] req;
    logic [7:0] key_in;
    logic [1:0] gnt;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport master (
        output req, key_in, in_valid, in_data, out_ready,
        input  gnt, in_ready, out_valid, out_data, out_last, busy, done
    );

    modport slave (
        input  req, key_in, in_valid, in_data, out_ready,
        output gnt, in_ready, out_valid, out_data, out_last, busy, done
    );
endinterface

// File: rtl/cipher_ctrl.sv
// cipher_ctrl: round-robin arbiter and job sequencer for the byte-serial shift cipher.
// Define CIPHER_CTRL_ALPHA_EN to shift only 'A'..'Z' with wrap inside the alphabet.
module cipher_ctrl #(
    parameter int MSG_LEN = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    cipher_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        DONE
    } state_t;

    localparam logic [7:0] LEN  = 8'(MSG_LEN);
    localparam logic [7:0] LAST = 8'(MSG_LEN - 1);

    state_t     state;
    logic [1:0] gnt;
    logic       mode;
    logic [7:0] key;
    logic [7:0] in_cnt;
    logic [7:0] out_cnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic       done;
    logic       busy;
    logic       ptr;

    logic       win;
    logic       in_ready;
    logic       out_last;
    logic       in_fire;
    logic       out_fire;

`ifdef CIPHER_CTRL_ALPHA_EN
    function automatic logic [7:0] fold_key(input logic [7:0] k);
        return k % 8'd26;
    endfunction

    // k is already reduced below 26, so one conditional subtract wraps
    function automatic logic [7:0] shift(
        input logic [7:0] b,
        input logic       dec,
        input logic [7:0] k
    );
        logic [7:0] off;
        logic [7:0] s;
        if (b < 8'h41 || b > 8'h5A) begin
            return b;
        end
        off = b - 8'h41;
        s   = dec ? (off + 8'd26 - k) : (off + k);
        if (s >= 8'd26) begin
            s = s - 8'd26;
        end
        return s + 8'h41;
    endfunction
`else
    function automatic logic [7:0] fold_key(input logic [7:0] k);
        return k;
    endfunction

    function automatic logic [7:0] shift(
        input logic [7:0] b,
        input logic       dec,
        input logic [7:0] k
    );
        return dec ? (b - k) : (b + k);
    endfunction
`endif

    // a lone request wins outright; on a tie the pointer picks the other side
    assign win = bus.req[1] & (~bus.req[0] | ~ptr);

    assign in_ready = (state == XFER) && (in_cnt < LEN)
                   && (!out_valid || bus.out_ready);
    assign out_last = out_valid && (out_cnt == LAST);
    assign in_fire  = bus.in_valid && in_ready;
    assign out_fire = out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= 2'b00;
            mode      <= 1'b0;
            key       <= 8'h00;
            in_cnt    <= 8'h00;
            out_cnt   <= 8'h00;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            done      <= 1'b0;
            busy      <= 1'b0;
            ptr       <= 1'b1;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state   <= XFER;
                        gnt     <= win ? 2'b10 : 2'b01;
                        mode    <= win;
                        ptr     <= win;
                        key     <= fold_key(bus.key_in);
                        in_cnt  <= 8'h00;
                        out_cnt <= 8'h00;
                        busy    <= 1'b1;
                    end
                end
                XFER: begin
                    if (in_fire) begin
                        out_valid <= 1'b1;
                        out_data  <= shift(bus.in_data, mode, key);
                        in_cnt    <= in_cnt + 8'd1;
                    end else if (out_fire) begin
                        out_valid <= 1'b0;
                    end
                    if (out_fire) begin
                        out_cnt <= out_cnt + 8'd1;
                        if (out_last) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.busy      = busy;
    assign bus.done      = done;

endmodule
